// File: rtl/tinh_gia_tri_pkg.sv
// Shared types and constants for the scientific-notation to fixed-point rebuilder.
package tinh_gia_tri_pkg;

    localparam int unsigned LEAD_W      = 4;
    localparam int unsigned FRAC_W      = 24;
    localparam int unsigned EXP_W       = 8;
    localparam int unsigned INT_W       = 24;
    localparam int unsigned ACC_W       = 27;
    localparam int unsigned DIGIT_W     = 4;
    localparam int unsigned FRAC_DIGITS = 7;
    localparam int unsigned MAX_EXP_POS = 6;
    localparam int unsigned MAX_EXP_NEG = 7;

    localparam logic [EXP_W-1:0]  CH_PLUS  = 8'h2B;
    localparam logic [EXP_W-1:0]  CH_MINUS = 8'h2D;
    localparam logic [LEAD_W-1:0] LEAD_MAX = 4'd9;
    localparam logic [FRAC_W-1:0] FRAC_MAX = 24'd9999999;
    localparam logic [ACC_W-1:0]  SCALE    = 27'd10000000;

    // k * 10^7 for k = 0..9; the comparators that extract the carry digit use it.
    localparam logic [ACC_W-1:0] K_TAB [10] = '{
        27'd0,        27'd10000000, 27'd20000000, 27'd30000000, 27'd40000000,
        27'd50000000, 27'd60000000, 27'd70000000, 27'd80000000, 27'd90000000
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [LEAD_W-1:0] lead;
        logic [FRAC_W-1:0] frac;
        logic [EXP_W-1:0]  mu;
        logic [EXP_W-1:0]  sign;
    } req_t;

endpackage

// File: rtl/tinh_gia_tri_if.sv
// Request/result bundle between the caller and the value rebuilder.
interface tinh_gia_tri_if;
    import tinh_gia_tri_pkg::*;

    logic              start;
    logic [LEAD_W-1:0] lead;
    logic [FRAC_W-1:0] frac_in;
    logic [EXP_W-1:0]  mu;
    logic [EXP_W-1:0]  mu1;
    logic [INT_W-1:0]  int_out;
    logic [FRAC_W-1:0] frac_out;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, lead, frac_in, mu, mu1,
        input  int_out, frac_out, busy, done, err
    );

    modport slave (
        input  start, lead, frac_in, mu, mu1,
        output int_out, frac_out, busy, done, err
    );
endinterface

// File: rtl/tinh_gia_tri_dec_digit_shift.sv
// One decimal digit step: x10 with carry digit into the integer ('+'), or truncating /10 ('-').
module dec_digit_shift
    import tinh_gia_tri_pkg::*;
(
    input  logic             plus_i,
    input  logic [INT_W-1:0] int_i,
    input  logic [ACC_W-1:0] acc_i,
    output logic [INT_W-1:0] int_o_c,
    output logic [ACC_W-1:0] acc_o_c
);

    logic [ACC_W-1:0]   p;
    logic [DIGIT_W-1:0] q;

    always_comb begin
        p       = ACC_W'(acc_i * ACC_W'(10));
        q       = '0;
        int_o_c = int_i;
        acc_o_c = acc_i;
        // Largest k with p >= k*10^7; table is monotonic so the last hit wins.
        for (int unsigned k = 1; k < 10; k++) begin
            if (p >= K_TAB[k]) q = DIGIT_W'(k);
        end
        if (plus_i) begin
            int_o_c = INT_W'(int_i * INT_W'(10)) + INT_W'(q);
            acc_o_c = p - K_TAB[q];
        end else begin
            acc_o_c = acc_i / ACC_W'(10);
        end
    end

endmodule

// File: rtl/tinh_gia_tri.sv
// Rebuilds integer part and 7-digit fraction from lead.frac x 10^(+/-mu), one digit per clock.
module tinh_gia_tri
    import tinh_gia_tri_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    tinh_gia_tri_if.slave bus
);

    state_e            state_q, state_d;
    req_t              req_q, req_d;
    logic [INT_W-1:0]  int_q, int_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [EXP_W-1:0]  cnt_q, cnt_d;
    logic [INT_W-1:0]  int_out_q, int_out_d;
    logic [FRAC_W-1:0] frac_out_q, frac_out_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              plus_c, minus_c, illegal_c;
    logic [INT_W-1:0]  step_int_c;
    logic [ACC_W-1:0]  step_acc_c;

    dec_digit_shift u_step (
        .plus_i  (plus_c),
        .int_i   (int_q),
        .acc_i   (acc_q),
        .int_o_c (step_int_c),
        .acc_o_c (step_acc_c)
    );

    always_comb begin
        plus_c    = (req_q.sign == CH_PLUS);
        minus_c   = (req_q.sign == CH_MINUS);
        illegal_c = (req_q.lead > LEAD_MAX) || (req_q.frac > FRAC_MAX) || !(plus_c || minus_c)
                  || (plus_c  && (req_q.mu > EXP_W'(MAX_EXP_POS)))
                  || (minus_c && (req_q.mu > EXP_W'(MAX_EXP_NEG)));
    end

    // Next state, datapath updates and result capture; results only change on entry to DONE.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        int_d      = int_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        int_out_d  = int_out_q;
        frac_out_d = frac_out_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    req_d   = '{lead: bus.lead, frac: bus.frac_in, mu: bus.mu, sign: bus.mu1};
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (illegal_c) begin
                    state_d    = DONE;
                    int_out_d  = '0;
                    frac_out_d = '0;
                    err_d      = 1'b1;
                end else if (req_q.mu == '0) begin
                    state_d    = DONE;
                    int_out_d  = INT_W'(req_q.lead);
                    frac_out_d = req_q.frac;
                    err_d      = 1'b0;
                end else begin
                    state_d = SHIFT;
                    cnt_d   = req_q.mu;
                    int_d   = INT_W'(req_q.lead);
                    acc_d   = plus_c ? ACC_W'(req_q.frac)
                                     : ACC_W'(req_q.lead) * SCALE + ACC_W'(req_q.frac);
                end
            end
            SHIFT: begin
                int_d = step_int_c;
                acc_d = step_acc_c;
                cnt_d = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d    = DONE;
                    int_out_d  = plus_c ? step_int_c : '0;
                    frac_out_d = step_acc_c[FRAC_W-1:0];
                    err_d      = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= '0;
            int_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            int_out_q  <= '0;
            frac_out_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            int_q      <= int_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            int_out_q  <= int_out_d;
            frac_out_q <= frac_out_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.int_out  = int_out_q;
    assign bus.frac_out = frac_out_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_tinh_gia_tri.sv
// Scoreboard bench for tinh_gia_tri: expectations from an arithmetic model, compared at done.
module tb_tinh_gia_tri;
    import tinh_gia_tri_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [INT_W-1:0]  i;
        logic [FRAC_W-1:0] f;
        logic              e;
        int                lat;
    } exp_t;

    exp_t sb[$];

    tinh_gia_tri_if bus ();

    tinh_gia_tri dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Whole-number model: scale by 10^mu in one go rather than digit by digit.
    function automatic exp_t model(input logic [3:0] lead, input logic [23:0] frac,
                                   input logic [7:0] mu, input logic [7:0] sg);
        exp_t   r;
        longint v;
        longint p10;
        r.i = '0; r.f = '0; r.e = 1'b0; r.lat = 2;
        if (lead > 9 || frac > 9999999 || !(sg == 8'h2B || sg == 8'h2D)
            || (sg == 8'h2B && mu > 6) || (sg == 8'h2D && mu > 7)) begin
            r.e = 1'b1;
            return r;
        end
        if (mu == 0) begin
            r.i = 24'(lead);
            r.f = frac;
            return r;
        end
        r.lat = int'(mu) + 2;
        v   = longint'(lead) * 10000000 + longint'(frac);
        p10 = 1;
        for (int k = 0; k < int'(mu); k++) p10 = p10 * 10;
        if (sg == 8'h2B) begin
            v   = v * p10;
            r.i = 24'(v / 10000000);
            r.f = 24'(v % 10000000);
        end else begin
            r.f = 24'(v / p10);
        end
        return r;
    endfunction

    // dup_at > 0: pulse start again in that cycle; dup_at < 0: pulse start in the DONE cycle.
    task automatic run_op(input logic [3:0] lead, input logic [23:0] frac, input logic [7:0] mu,
                          input logic [7:0] sg, input int dup_at, input string name);
        exp_t e;
        int   n;
        bit   seen;
        sb.push_back(model(lead, frac, mu, sg));
        @(negedge clk);
        bus.lead = lead; bus.frac_in = frac; bus.mu = mu; bus.mu1 = sg; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 1;
        total++;
        if (bus.busy !== 1'b1) begin
            bad++; $display("FAIL %s busy_load got=%b want=1", name, bus.busy);
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.done === 1'b1) begin seen = 1'b1; break; end
            if (n == dup_at) begin
                bus.start = 1'b1; bus.lead = 4'd3; bus.frac_in = 24'd1; bus.mu = 8'd1; bus.mu1 = 8'h2D;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            n++;
        end
        e = sb.pop_front();
        total++;
        if (!seen) begin
            bad++; $display("FAIL %s done_timeout got=none want=cycle%0d", name, e.lat);
        end else begin
            total++;
            if (n != e.lat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, n, e.lat); end
            total++;
            if (bus.int_out !== e.i) begin bad++; $display("FAIL %s int_out got=%0d want=%0d", name, bus.int_out, e.i); end
            total++;
            if (bus.frac_out !== e.f) begin bad++; $display("FAIL %s frac_out got=%0d want=%0d", name, bus.frac_out, e.f); end
            total++;
            if (bus.err !== e.e) begin bad++; $display("FAIL %s err got=%b want=%b", name, bus.err, e.e); end
            total++;
            if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s busy_done got=%b want=1", name, bus.busy); end
            if (dup_at < 0) bus.start = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        total++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL %s after_done got=done%b/busy%b want=0/0", name, bus.done, bus.busy);
        end
        total++;
        if (bus.int_out !== e.i || bus.frac_out !== e.f) begin
            bad++; $display("FAIL %s hold got=%0d.%0d want=%0d.%0d", name, bus.int_out, bus.frac_out, e.i, e.f);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.lead = '0; bus.frac_in = '0; bus.mu = '0; bus.mu1 = '0;
        #1;
        total++;
        if (bus.int_out !== '0 || bus.frac_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got=%0d/%0d/%b%b%b want=0/0/000",
                     bus.int_out, bus.frac_out, bus.busy, bus.done, bus.err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_plus();
        run_op(4'd2, 24'd4000000, 8'd1, CH_PLUS, 0, "plus_2.4e1");
        run_op(4'd1, 24'd0426000, 8'd3, CH_PLUS, 0, "plus_1.0426e3");
        run_op(4'd9, 24'd9999999, 8'd6, CH_PLUS, 0, "plus_max");
    endtask

    task automatic test_minus();
        run_op(4'd1, 24'd2345678, 8'd2, CH_MINUS, 0, "minus_1.2345678e-2");
        run_op(4'd5, 24'd0,       8'd1, CH_MINUS, 0, "minus_5e-1");
        run_op(4'd9, 24'd9999999, 8'd7, CH_MINUS, 0, "minus_max");
    endtask

    task automatic test_mu_zero();
        run_op(4'd7, 24'd1, 8'd0, CH_MINUS, 0, "mu0_minus");
    endtask

    task automatic test_errors();
        run_op(4'd1, 24'd5, 8'd7,  CH_PLUS,  0, "err_mu7_plus");
        run_op(4'd1, 24'd5, 8'd2,  8'h41,    0, "err_sign");
        run_op(4'd4, 24'd5, 8'd8,  CH_MINUS, 0, "err_mu8_minus");
        run_op(4'd10, 24'd0, 8'd1, CH_PLUS,  0, "err_lead");
        run_op(4'd1, 24'd10000000, 8'd1, CH_PLUS, 0, "err_frac");
    endtask

    task automatic test_back_to_back();
        run_op(4'd3, 24'd1415926, 8'd4, CH_PLUS, 2, "start_in_shift");
        run_op(4'd6, 24'd0250000, 8'd2, CH_PLUS, -1, "start_in_done");
        run_op(4'd8, 24'd7654321, 8'd3, CH_MINUS, 0, "after_done_start");
    endtask

    task automatic test_abort();
        bit saw_done;
        run_op(4'd2, 24'd7182818, 8'd2, CH_PLUS, 0, "pre_abort");
        @(negedge clk);
        bus.lead = 4'd1; bus.frac_in = 24'd1234567; bus.mu = 8'd5; bus.mu1 = CH_PLUS; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.int_out !== '0 || bus.frac_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++;
            $display("FAIL abort_reset got=%0d/%0d/busy%b/done%b want=0/0/0/0",
                     bus.int_out, bus.frac_out, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin bad++; $display("FAIL abort_no_done got=activity want=idle"); end
        run_op(4'd1, 24'd5000000, 8'd1, CH_PLUS, 0, "post_abort");
    endtask

    task automatic test_random();
        logic [3:0]  l;
        logic [23:0] f;
        logic [7:0]  m;
        logic [7:0]  s;
        for (int r = 0; r < 8; r++) begin
            l = 4'($urandom_range(0, 9));
            f = 24'($urandom_range(0, 9999999));
            s = ($urandom_range(0, 1) == 0) ? CH_PLUS : CH_MINUS;
            m = 8'($urandom_range(0, (s == CH_PLUS) ? 6 : 7));
            run_op(l, f, m, s, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_plus();
        test_minus();
        test_mu_zero();
        test_errors();
        test_back_to_back();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
